// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
//
// Online perceptron predictor with in-line training. Each accepted sample
// (in_valid=1) produces a registered prediction for its 8-bit history one
// cycle later. When a prediction is outstanding, the next accepted sample
// carries that prediction's actual outcome (workload). The outcome is scored
// against the stored prediction and, when allowed, used to train the weights.
//
// Parameters
//   W       signed weight/bias width (4..12)
//   THRESH  confidence margin: low-confidence sums (|y| <= THRESH) also train
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low clear of all state
//   in_valid          sample strobe for hist/workload
//   hist[7:0]         global history; bit i = outcome i+1 samples ago
//   workload          actual outcome of the previously issued prediction
//   train_en          1 allows weight/bias updates, 0 freezes them
//   predict           registered prediction (sum >= 0)
//   pred_valid        one-cycle pulse for a new prediction
//   upd               one-cycle pulse for a weight/bias update
//   mispredict_count  saturating count of wrong predictions
//   rd_idx[3:0]       0..7 select w0..w7, 8 selects bias, 9..15 read zero
//   rd_data[W-1:0]    combinational read of the selected weight
// -----------------------------------------------------------------------------
module perceptron_trainer #(
   parameter int W      = 8,
   parameter int THRESH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [7:0]          hist,
   input  logic                workload,
   input  logic                train_en,
   output logic                predict,
   output logic                pred_valid,
   output logic                upd,
   output logic [15:0]         mispredict_count,
   input  logic [3:0]          rd_idx,
   output logic signed [W-1:0] rd_data
);

   // Sum width: nine terms of magnitude <= 2^(W-1)-1 fit in W+4 signed bits.
   localparam int YW = W + 4;

   // Symmetric saturation limits; the most negative code is never produced.
   localparam logic signed [W-1:0] W_MAX    = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] W_MIN    = {1'b1, {(W-2){1'b0}}, 1'b1};
   localparam logic signed [W-1:0] ONE      = W'(1);
   localparam logic [YW-1:0]       THRESH_V = YW'(THRESH);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_PEND  = 1'b1
   } state_t;

   // Index 8 of the weight arrays is the bias.
   state_t                 state_q;
   logic signed [W-1:0]    w_q [0:8];
   logic signed [W-1:0]    w_d [0:8];
   logic [7:0]             hist_q;
   logic signed [YW-1:0]   y_q;
   logic signed [YW-1:0]   y_d;
   logic                   predict_q;
   logic                   pred_valid_q;
   logic                   upd_q;
   logic [15:0]            cnt_q;

   logic signed [YW-1:0]   w_ext [0:8];
   logic signed [YW-1:0]   term  [0:7];
   logic [YW-1:0]          y_abs;
   logic                   accept_pend;
   logic                   mispredict;
   logic                   y_small;
   logic                   do_train;
   logic [8:0]             agree;

   // ---------------------------------------------------------------------
   // Scoring of the outstanding prediction
   // ---------------------------------------------------------------------
   assign accept_pend = in_valid & (state_q == ST_PEND);
   assign mispredict  = accept_pend & (predict_q != workload);

   // y_q never reaches the most negative YW-bit code, so negation is safe.
   assign y_abs    = y_q[YW-1] ? -y_q : y_q;
   assign y_small  = (y_abs <= THRESH_V);
   assign do_train = accept_pend & train_en & (mispredict | y_small);

   // A weight moves toward agreement between its history bit and the outcome;
   // the bias moves toward the outcome itself.
   assign agree = {workload, ~(hist_q ^ {8{workload}})};

   // ---------------------------------------------------------------------
   // Per-weight update with symmetric saturation and sign extension
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_weight
         assign w_d[gi] = !do_train ? w_q[gi] :
                          agree[gi] ? ((w_q[gi] == W_MAX) ? W_MAX : w_q[gi] + ONE) :
                                      ((w_q[gi] == W_MIN) ? W_MIN : w_q[gi] - ONE);
         assign w_ext[gi] = {{4{w_q[gi][W-1]}}, w_q[gi]};
      end
   endgenerate

   // ---------------------------------------------------------------------
   // New sum from the incoming history, using pre-update weights
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_term
         assign term[gi] = hist[gi] ? w_ext[gi] : -w_ext[gi];
      end
   endgenerate

   always_comb begin
      y_d = w_ext[8];
      for (int i = 0; i < 8; i++) begin
         y_d = y_d + term[i];
      end
   end

   // ---------------------------------------------------------------------
   // State: FSM, prediction, scoring counter and weights
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_EMPTY;
         hist_q       <= '0;
         y_q          <= '0;
         predict_q    <= 1'b0;
         pred_valid_q <= 1'b0;
         upd_q        <= 1'b0;
         cnt_q        <= '0;
         for (int i = 0; i < 9; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         pred_valid_q <= in_valid;
         upd_q        <= do_train;

         if (in_valid) begin
            // Both states move to PEND on an accepted sample; EMPTY simply
            // skipped the scoring above because accept_pend was low.
            case (state_q)
               ST_EMPTY: state_q <= ST_PEND;
               ST_PEND:  state_q <= ST_PEND;
               default:  state_q <= ST_EMPTY;
            endcase
            hist_q    <= hist;
            y_q       <= y_d;
            predict_q <= ~y_d[YW-1];
         end

         if (mispredict && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end

         for (int i = 0; i < 9; i++) begin
            w_q[i] <= w_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign predict          = predict_q;
   assign pred_valid       = pred_valid_q;
   assign upd              = upd_q;
   assign mispredict_count = cnt_q;

   always_comb begin
      rd_data = '0;
      if (rd_idx <= 4'd8) begin
         rd_data = w_q[rd_idx];
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  hist;
   logic        workload;
   logic        train_en;
   logic [3:0]  rd_idx;

   logic              predict8, pred_valid8, upd8;
   logic [15:0]       cnt8;
   logic signed [7:0] rd_data8;
   logic              predict4, pred_valid4, upd4;
   logic [15:0]       cnt4;
   logic signed [3:0] rd_data4;

   int vectors = 0;
   int errors  = 0;

   always #10 clk = ~clk;

   perceptron_trainer #(.W(8), .THRESH(4)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .hist(hist),
      .workload(workload), .train_en(train_en), .predict(predict8),
      .pred_valid(pred_valid8), .upd(upd8), .mispredict_count(cnt8),
      .rd_idx(rd_idx), .rd_data(rd_data8)
   );

   // Large margin keeps the narrow instance training so it reaches saturation.
   perceptron_trainer #(.W(4), .THRESH(70)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .hist(hist),
      .workload(workload), .train_en(train_en), .predict(predict4),
      .pred_valid(pred_valid4), .upd(upd4), .mispredict_count(cnt4),
      .rd_idx(rd_idx), .rd_data(rd_data4)
   );

   typedef struct {
      logic pred;
      logic upd;
      int   cnt;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   // Reference model state: index 0 = W=8 instance, 1 = W=4 instance.
   int         mw    [2][9];
   int         mpend [2];
   int         mpred [2];
   int         my    [2];
   logic [7:0] mhist [2];
   int         mcnt  [2];
   int         mmax  [2];
   int         mth   [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 9; i++) mw[k][i] = 0;
         mpend[k] = 0;
         mpred[k] = 0;
         my[k]    = 0;
         mhist[k] = '0;
         mcnt[k]  = 0;
      end
   endtask

   task automatic model_accept(input int k, input logic [7:0] h, input logic wl,
                               input logic te, output exp_t e);
      int y;
      int ay;
      bit mis;
      bit tr;
      bit agr;
      y = mw[k][8];
      for (int i = 0; i < 8; i++) y += h[i] ? mw[k][i] : -mw[k][i];
      tr = 1'b0;
      if (mpend[k] != 0) begin
         mis = (mpred[k] != int'(wl));
         if (mis && mcnt[k] < 65535) mcnt[k]++;
         ay = (my[k] < 0) ? -my[k] : my[k];
         tr = te && (mis || ay <= mth[k]);
         if (tr) begin
            for (int i = 0; i < 9; i++) begin
               agr = (i == 8) ? wl : (mhist[k][i] == wl);
               mw[k][i] += agr ? 1 : -1;
               if (mw[k][i] >  mmax[k]) mw[k][i] =  mmax[k];
               if (mw[k][i] < -mmax[k]) mw[k][i] = -mmax[k];
            end
         end
      end
      mpend[k] = 1;
      mpred[k] = (y >= 0) ? 1 : 0;
      my[k]    = y;
      mhist[k] = h;
      e.pred   = (y >= 0);
      e.upd    = tr;
      e.cnt    = mcnt[k];
   endtask

   // Drive one cycle of stimulus, then check outputs 1 time unit after the edge.
   task automatic step(input logic v, input logic [7:0] h, input logic wl, input logic te);
      exp_t e;
      in_valid = v;
      hist     = h;
      workload = wl;
      train_en = te;
      if (v) begin
         model_accept(0, h, wl, te, e);
         sb0.push_back(e);
         model_accept(1, h, wl, te, e);
         sb1.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("pv8", pred_valid8, 32'(v));
      chk("pv4", pred_valid4, 32'(v));
      if (pred_valid8 === 1'b1 && sb0.size() > 0) begin
         e = sb0.pop_front();
         chk("pred8", predict8, 32'(e.pred));
         chk("upd8", upd8, 32'(e.upd));
         chk("cnt8", cnt8, e.cnt);
      end else begin
         sb0.delete();
         chk("idle_upd8", upd8, 0);
         chk("idle_cnt8", cnt8, mcnt[0]);
      end
      if (pred_valid4 === 1'b1 && sb1.size() > 0) begin
         e = sb1.pop_front();
         chk("pred4", predict4, 32'(e.pred));
         chk("upd4", upd4, 32'(e.upd));
         chk("cnt4", cnt4, e.cnt);
      end else begin
         sb1.delete();
         chk("idle_upd4", upd4, 0);
         chk("idle_cnt4", cnt4, mcnt[1]);
      end
   endtask

   // Read back all weights (plus out-of-range indices) within the current
   // cycle, then spend one idle cycle to realign with the clock.
   task automatic check_weights();
      int idx;
      in_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         idx    = (i == 10) ? 15 : i;
         rd_idx = 4'(idx);
         #1;
         chk($sformatf("w8_%0d", idx), rd_data8, (idx <= 8) ? mw[0][idx] : 0);
         chk($sformatf("w4_%0d", idx), rd_data4, (idx <= 8) ? mw[1][idx] : 0);
      end
      step(1'b0, hist, workload, train_en);
   endtask

   // Assert reset mid-cycle, check the asynchronous clear, release after an edge.
   task automatic do_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_pv8", pred_valid8, 0);
      chk("rst_upd8", upd8, 0);
      chk("rst_pred8", predict8, 0);
      chk("rst_cnt8", cnt8, 0);
      chk("rst_pv4", pred_valid4, 0);
      chk("rst_cnt4", cnt4, 0);
      model_reset();
      sb0.delete();
      sb1.delete();
      check_weights();
      reset = 1'b1;
   endtask

   initial begin
      int         c;
      logic [7:0] hreg;
      logic       wl;

      mmax[0] = 127;
      mmax[1] = 7;
      mth[0]  = 4;
      mth[1]  = 70;
      reset    = 1'b0;
      in_valid = 1'b0;
      hist     = 8'h00;
      workload = 1'b0;
      train_en = 1'b0;
      rd_idx   = 4'd0;
      model_reset();

      @(posedge clk);
      #1;
      do_reset();

      // First prediction after reset: all-zero weights give y=0, predict=1.
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("first_pred", predict8, 1);
      chk("first_upd", upd8, 0);

      // Outcome 0 against prediction 1: count and train every weight to -1.
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("train_cnt", cnt8, 1);
      chk("train_upd", upd8, 1);
      rd_idx = 4'd0;
      #1;
      chk("w0_minus1", rd_data8, -1);
      rd_idx = 4'd8;
      #1;
      chk("bias_minus1", rd_data8, -1);
      check_weights();

      // Training frozen: ten mispredicting samples only bump the count.
      c = mcnt[0];
      for (int n = 0; n < 10; n++) begin
         wl = (mpred[0] == 0);
         step(1'b1, 8'hFF, wl, 1'b0);
      end
      chk("frozen_cnt", cnt8, c + 10);
      check_weights();

      // Narrow-weight saturation at +7, never -8.
      do_reset();
      for (int n = 0; n < 20; n++) step(1'b1, 8'hFF, 1'b1, 1'b1);
      check_weights();
      for (int i = 0; i < 9; i++) begin
         rd_idx = 4'(i);
         #1;
         chk($sformatf("sat4_%0d", i), rd_data4, 7);
      end
      chk("sat4_pred", predict4, 1);
      step(1'b0, 8'hFF, 1'b1, 1'b1);

      // Reset while a prediction is pending discards it.
      step(1'b1, 8'h5A, 1'b1, 1'b1);
      do_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b1);
      chk("post_rst_cnt", cnt8, 0);
      chk("post_rst_upd", upd8, 0);

      // Back-to-back stream: 40 ones, then 200 zeros, real history shifted in.
      hreg = 8'h00;
      for (int n = 0; n < 40; n++) begin
         step(1'b1, hreg, 1'b1, 1'b1);
         hreg = {hreg[6:0], 1'b1};
      end
      c = int'(cnt8);
      for (int n = 0; n < 200; n++) begin
         step(1'b1, hreg, 1'b0, 1'b1);
         hreg = {hreg[6:0], 1'b0};
      end
      chk("tail_pred", predict8, 0);
      chk("tail_cnt_small", 32'((int'(cnt8) - c) <= 24), 1);
      check_weights();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
